// File: rtl/srff_bist_driver.sv
// Built-in self-test master for an SR flip-flop: walks a fixed 13-step vector ROM,
// checks q/qb against a golden model after each step and reports pass/fail.
module srff_bist_driver #(
    parameter int HOLD_CYC = 2,
    parameter int ERR_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [1:0]       sr_out,
    output logic             dut_rst,
    input  logic             q_in,
    input  logic             qb_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_step
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);
    localparam logic [3:0] LAST_STEP = 4'd12;

    logic [1:0] state;
    logic [3:0] step;
    logic [3:0] hold;
    logic       gold_q;
    logic       gold_known;

    logic [2:0] act;
    logic       nxt_q;
    logic       nxt_known;
    logic       step_fail;

    // Vector ROM entry as {rst, S, R}; a reset step always drives sr=00.
    function automatic logic [2:0] rom_action(input logic [3:0] idx);
        case (idx)
            4'd0:    return 3'b100;
            4'd1:    return 3'b000;
            4'd2:    return 3'b001;
            4'd3:    return 3'b010;
            4'd4:    return 3'b011;
            4'd5:    return 3'b100;
            4'd6:    return 3'b011;
            4'd7:    return 3'b010;
            4'd8:    return 3'b001;
            4'd9:    return 3'b000;
            4'd10:   return 3'b100;
            4'd11:   return 3'b010;
            4'd12:   return 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        act       = rom_action(step);
        nxt_q     = gold_q;
        nxt_known = gold_known;
        if (act[2] || act[1:0] == 2'b01) begin
            nxt_q     = 1'b0;
            nxt_known = 1'b1;
        end else if (act[1:0] == 2'b10) begin
            nxt_q     = 1'b1;
            nxt_known = 1'b1;
        end else if (act[1:0] == 2'b11) begin
            nxt_known = 1'b0;
        end
        // The illegal 11 code leaves the model unknown, so it is never checked.
        step_fail = nxt_known && ((q_in != nxt_q) || (qb_in != ~nxt_q));
    end

    always_comb begin
        busy    = (state == APPLY) || (state == CHECK);
        done    = (state == DONE);
        pass    = done && (err_count == '0);
        dut_rst = busy && act[2];
        sr_out  = (busy && !act[2]) ? act[1:0] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            step       <= 4'd0;
            hold       <= 4'd0;
            err_count  <= '0;
            fail_step  <= 4'd0;
            gold_q     <= 1'b0;
            gold_known <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= '0;
                        fail_step <= 4'd0;
                        step      <= 4'd0;
                        hold      <= 4'd0;
                        state     <= APPLY;
                    end
                end
                APPLY: begin
                    if (hold == HOLD_LAST) begin
                        hold  <= 4'd0;
                        state <= CHECK;
                    end else begin
                        hold <= hold + 4'd1;
                    end
                end
                CHECK: begin
                    gold_q     <= nxt_q;
                    gold_known <= nxt_known;
                    if (step_fail) begin
                        err_count <= sat_inc(err_count);
                        if (err_count == '0)
                            fail_step <= step;
                    end
                    if (step == LAST_STEP) begin
                        state <= DONE;
                    end else begin
                        step  <= step + 4'd1;
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_srff_bist_driver.sv
// Bench for srff_bist_driver: drives two instances (HOLD_CYC=2 and 1) beside behavioural
// SR flip-flops with injectable faults and checks traces and results against a table model.
module tb_srff_bist_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start1;
    logic [1:0] sr_out, sr_out1;
    logic       dut_rst, dut_rst1;
    logic       q_in, qb_in, q_in1, qb_in1;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [3:0] err_count, fail_step, err_count1, fail_step1;

    int   fault;
    logic ff_q, ff_q1;

    srff_bist_driver #(.HOLD_CYC(2), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sr_out(sr_out), .dut_rst(dut_rst),
        .q_in(q_in), .qb_in(qb_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_step(fail_step)
    );

    srff_bist_driver #(.HOLD_CYC(1), .ERR_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sr_out(sr_out1), .dut_rst(dut_rst1),
        .q_in(q_in1), .qb_in(qb_in1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_step(fail_step1)
    );

    // Flip-flops under test; fault 1 = q stuck at 0, fault 2 = qb tied to q.
    always_ff @(posedge clk) begin
        if (rst || dut_rst) ff_q <= 1'b0;
        else if (sr_out == 2'b01) ff_q <= 1'b0;
        else if (sr_out == 2'b10) ff_q <= 1'b1;
        else if (sr_out == 2'b11) ff_q <= 1'b0;
        else ff_q <= ff_q;
    end
    assign q_in  = (fault == 1) ? 1'b0 : ff_q;
    assign qb_in = (fault == 2) ? q_in : ~q_in;

    always_ff @(posedge clk) begin
        if (rst || dut_rst1) ff_q1 <= 1'b0;
        else if (sr_out1 == 2'b01) ff_q1 <= 1'b0;
        else if (sr_out1 == 2'b10) ff_q1 <= 1'b1;
        else if (sr_out1 == 2'b11) ff_q1 <= 1'b1;
        else ff_q1 <= ff_q1;
    end
    assign q_in1  = ff_q1;
    assign qb_in1 = ~ff_q1;

    // Vector table: reset flag, sr code, expected q and whether q is knowable.
    bit       t_rst   [13] = '{1,0,0,0,0,1,0,0,0,0,1,0,0};
    bit [1:0] t_sr    [13] = '{0,0,1,2,3,0,3,2,1,0,0,2,0};
    bit       t_q     [13] = '{0,0,0,1,0,0,0,1,0,0,0,1,1};
    bit       t_known [13] = '{1,1,1,1,0,1,0,1,1,1,1,1,1};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic predict(input int f, output int e_err, output int e_fail);
        bit oq, oqb;
        e_err  = 0;
        e_fail = 0;
        for (int i = 0; i < 13; i++) begin
            if (t_known[i]) begin
                oq  = (f == 1) ? 1'b0 : t_q[i];
                oqb = (f == 2) ? oq : ~oq;
                if (oq != t_q[i] || oqb != ~t_q[i]) begin
                    if (e_err == 0) e_fail = i;
                    if (e_err < 15) e_err++;
                end
            end
        end
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_sr_out"}, sr_out, 0);
        check({pfx, "_dut_rst"}, dut_rst, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_pass"}, pass, 0);
        check({pfx, "_err_count"}, err_count, 0);
        check({pfx, "_fail_step"}, fail_step, 0);
    endtask

    // One run of the HOLD_CYC=2 instance; abort_c >= 0 pulses rst at that cycle of the run.
    task automatic run(input int f, input bit dup_start, input int abort_c);
        int e_err, e_fail, s;
        fault = f;
        repeat ($urandom_range(0, 3)) tick();
        predict(f, e_err, e_fail);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 39; c++) begin
            if (c == abort_c) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_reset_state("abort");
                return;
            end
            s = c / 3;
            check("trace_sr_out", sr_out, t_rst[s] ? 2'b00 : t_sr[s]);
            check("trace_dut_rst", dut_rst, t_rst[s]);
            check("trace_busy", busy, 1);
            check("trace_done", done, 0);
            start = dup_start && (c == 12);
            tick();
            start = 1'b0;
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_pass", pass, (e_err == 0) ? 1 : 0);
        check("end_err_count", err_count, e_err);
        check("end_fail_step", fail_step, e_fail);
        check("end_sr_out", sr_out, 0);
        check("end_dut_rst", dut_rst, 0);
    endtask

    initial begin
        int f;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        fault  = 0;
        tick();
        tick();
        check_reset_state("reset");
        check("reset_done1", done1, 0);
        rst = 1'b0;
        tick();

        run(0, 1'b0, -1);
        run(1, 1'b0, -1);
        run(2, 1'b0, -1);
        run(0, 1'b1, -1);

        f = $urandom_range(1, 2);
        run(f, 1'b0, 16);
        run(f, 1'b0, -1);

        for (int i = 0; i < 4; i++)
            run($urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);

        // HOLD_CYC=1 instance with a good flip-flop.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 26; c++) begin
            check("h1_sr_out", sr_out1, t_rst[c / 2] ? 2'b00 : t_sr[c / 2]);
            check("h1_dut_rst", dut_rst1, t_rst[c / 2]);
            check("h1_done", done1, 0);
            tick();
        end
        check("h1_end_done", done1, 1);
        check("h1_end_pass", pass1, 1);
        check("h1_end_err_count", err_count1, 0);
        check("h1_end_fail_step", fail_step1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
